// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type codes, port indices, flit field offsets,
// output-port lock states and a wrap-around port increment helper.
package noc_pkg;

  localparam logic [1:0] FLIT_SINGLE = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_BODY   = 2'b10;
  localparam logic [1:0] FLIT_TAIL   = 2'b11;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_W = 2;
  localparam int PORT_E = 3;
  localparam int PORT_L = 4;

  localparam int DST_MSB  = 35;
  localparam int DST_LSB  = 32;
  localparam int TYPE_MSB = 1;
  localparam int TYPE_LSB = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int unsigned next_port(input int unsigned idx, input int unsigned nport);
    return (idx + 1 >= nport) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sa_out_port_if.sv
// Request/flit/credit bundle between the input buffers, link and one output port.
// master = buffers/link side, slave = the output-port controller.
interface sa_out_port_if #(
  parameter int NPORT    = 5,
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3
);
  logic [NPORT-1:0]          req_in;
  logic [NPORT*DATASIZE-1:0] data_in;
  logic [NPORT-1:0]          grant_out;
  logic [DATASIZE-1:0]       data_out;
  logic                      valid_out;
  logic                      credit_in;
  logic [WIDTH:0]            pressure_out;
  logic                      lock_err;

  modport master (
    output req_in, data_in, credit_in,
    input  grant_out, data_out, valid_out, pressure_out, lock_err
  );

  modport slave (
    input  req_in, data_in, credit_in,
    output grant_out, data_out, valid_out, pressure_out, lock_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans ptr, ptr+1, ... (mod NPORT) and returns
// the first requester as one-hot grant plus encoded index. ptr must be < NPORT.
module rr_arbiter #(
  parameter int NPORT = 5,
  parameter int IW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [NPORT-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  // cand[k] is the port inspected at scan position k
  logic [IW:0] cand [NPORT];

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum      = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi] = (sum >= (IW+1)'(NPORT)) ? sum - (IW+1)'(NPORT) : sum;
    end
  endgenerate

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (req[cand[k][IW-1:0]]) begin
        idx   = cand[k][IW-1:0];
        valid = 1'b1;
      end
    end
    grant = valid ? (NPORT'(1) << idx) : '0;
  end

endmodule

// File: rtl/sa_out_port.sv
// Switch allocator + output-port controller for one router direction: round-robin
// grant with wormhole lock, registered link flit, downstream credit tracking.
// Optional lock watchdog enabled by defining SA_LOCK_TIMEOUT_EN.
module sa_out_port
  import noc_pkg::*;
#(
  parameter int NPORT    = 5,
  parameter int DATASIZE = 40,
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int TO_W     = 6
) (
  input  logic         sa_clk,
  input  logic         rst,
  sa_out_port_if.slave bus
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [WIDTH:0] DEPTH_C = (WIDTH+1)'(DEPTH);

  state_t              state_reg;
  logic [IW-1:0]       ptr_reg;
  logic [IW-1:0]       owner_reg;
  logic [WIDTH:0]      credit_reg;
  logic [WIDTH:0]      credit_next;
  logic [WIDTH:0]      pressure_reg;
  logic [DATASIZE-1:0] data_reg;
  logic                valid_reg;

  logic [NPORT-1:0]    arb_req;
  logic [NPORT-1:0]    arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;
  logic                xfer;
  logic [DATASIZE-1:0] sel_flit;
  logic [1:0]          sel_type;
  logic [IW-1:0]       win_next_ptr;
  logic [IW-1:0]       owner_next_ptr;

  logic [DATASIZE-1:0] flits [NPORT];

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_flit
      assign flits[gi] = bus.data_in[gi*DATASIZE +: DATASIZE];
    end
  endgenerate

  // While locked, the owner is the only visible requester
  always_comb begin
    arb_req = bus.req_in;
    if (state_reg == LOCKED) begin
      arb_req = bus.req_in & (NPORT'(1) << owner_reg);
    end
  end

  rr_arbiter #(.NPORT(NPORT), .IW(IW)) u_arb (
    .req   (arb_req),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign xfer           = arb_valid && (credit_reg != '0);
  assign bus.grant_out  = xfer ? arb_grant : '0;
  assign sel_flit       = flits[arb_idx];
  assign sel_type       = sel_flit[TYPE_MSB:TYPE_LSB];
  assign win_next_ptr   = IW'(next_port(32'(arb_idx), NPORT));
  assign owner_next_ptr = IW'(next_port(32'(owner_reg), NPORT));

  always_comb begin
    credit_next = credit_reg;
    if (xfer && !bus.credit_in) begin
      credit_next = credit_reg - 1'b1;
    end else if (!xfer && bus.credit_in && credit_reg != DEPTH_C) begin
      credit_next = credit_reg + 1'b1;
    end
  end

`ifdef SA_LOCK_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - 1'b1;
  logic [TO_W-1:0] to_cnt_reg;
  logic            lock_err_reg;
  logic            to_fire;

  // Fires on the idle cycle that brings the counter to all-ones
  assign to_fire = (state_reg == LOCKED) && !bus.req_in[owner_reg] && (to_cnt_reg == TO_LAST);

  always_ff @(posedge sa_clk) begin
    if (rst) begin
      to_cnt_reg   <= '0;
      lock_err_reg <= 1'b0;
    end else begin
      if (state_reg != LOCKED || xfer) begin
        to_cnt_reg <= '0;
      end else if (!bus.req_in[owner_reg]) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      if (to_fire) begin
        lock_err_reg <= 1'b1;
      end
    end
  end

  assign bus.lock_err = lock_err_reg;
`else
  logic unused_to;
  assign unused_to    = (TO_W > 0);
  assign bus.lock_err = 1'b0;
`endif

  always_ff @(posedge sa_clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      credit_reg   <= DEPTH_C;
      pressure_reg <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg    <= xfer;
      credit_reg   <= credit_next;
      pressure_reg <= DEPTH_C - credit_next;
      if (xfer) begin
        data_reg <= sel_flit;
      end
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            case (sel_type)
              FLIT_HEAD: begin
                state_reg <= LOCKED;
                owner_reg <= arb_idx;
              end
              // Body/tail without a lock is treated as a stand-alone flit
              FLIT_SINGLE, FLIT_BODY, FLIT_TAIL: ptr_reg <= win_next_ptr;
              default: ptr_reg <= win_next_ptr;
            endcase
          end
        end
        LOCKED: begin
          if (xfer && sel_type == FLIT_TAIL) begin
            state_reg <= IDLE;
            ptr_reg   <= owner_next_ptr;
          end
`ifdef SA_LOCK_TIMEOUT_EN
          else if (to_fire) begin
            state_reg <= IDLE;
            ptr_reg   <= owner_next_ptr;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.data_out     = data_reg;
  assign bus.valid_out    = valid_reg;
  assign bus.pressure_out = pressure_reg;

endmodule

// File: tb/tb_sa_out_port.sv
// Directed bench for sa_out_port: expected link flits are queued when a grant is
// expected and popped when valid_out shows them; credits tracked by a small model.
module tb_sa_out_port;
  import noc_pkg::*;

  localparam int NP = 5;
  localparam int DS = 40;
  localparam int DP = 8;

  logic sa_clk;
  logic rst;

  sa_out_port_if #(.NPORT(NP), .DATASIZE(DS), .WIDTH(3)) bus ();

  sa_out_port #(.NPORT(NP), .DATASIZE(DS), .DEPTH(DP), .WIDTH(3), .TO_W(3)) dut (
    .sa_clk (sa_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial sa_clk = 1'b0;
  always #5 sa_clk = ~sa_clk;

  int            tests = 0;
  int            fails = 0;
  logic [DS-1:0] sb_q [$];
  int            model_cr = DP;
  logic [DS-1:0] last_flit = '0;
  logic          exp_lock_err = 1'b0;

  function automatic logic [DS-1:0] mk(input logic [3:0] src, input logic [1:0] typ,
                                       input logic [29:0] pay);
    logic [DS-1:0] f;
    f = '0;
    f[39:36] = src;
    f[DST_MSB:DST_LSB] = 4'hA;
    f[31:2] = pay;
    f[TYPE_MSB:TYPE_LSB] = typ;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flit(input int p, input logic [DS-1:0] f);
    bus.data_in[p*DS +: DS] = f;
  endtask

  // One clock cycle starting at a negedge with inputs already driven
  task automatic cycle(input logic [NP-1:0] exp_g);
    logic          xf;
    logic [DS-1:0] exp_d;
    #1;
    chk("grant", 64'(bus.grant_out), 64'(exp_g));
    xf = (exp_g != '0);
    for (int p = 0; p < NP; p++) begin
      if (exp_g[p]) sb_q.push_back(bus.data_in[p*DS +: DS]);
    end
    if (xf && !bus.credit_in) model_cr--;
    else if (!xf && bus.credit_in && model_cr < DP) model_cr++;
    @(posedge sa_clk);
    #1;
    chk("valid", 64'(bus.valid_out), 64'(xf));
    if (bus.valid_out === 1'b1) begin
      exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      chk("data", 64'(bus.data_out), 64'(exp_d));
      last_flit = exp_d;
    end else begin
      chk("data_hold", 64'(bus.data_out), 64'(last_flit));
    end
    chk("pressure", 64'(bus.pressure_out), 64'(DP - model_cr));
    chk("lock_err", 64'(bus.lock_err), 64'(exp_lock_err));
    $display("[TB] t=%0t grant=%b valid=%b data=%h pressure=%0d", $time, exp_g,
             bus.valid_out, bus.data_out, bus.pressure_out);
    @(negedge sa_clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_in = '0;
    bus.credit_in = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge sa_clk);
    #1;
    chk("rst_valid", 64'(bus.valid_out), 64'(0));
    chk("rst_data", 64'(bus.data_out), 64'(0));
    chk("rst_pressure", 64'(bus.pressure_out), 64'(0));
    chk("rst_lock_err", 64'(bus.lock_err), 64'(0));
    chk("rst_grant", 64'(bus.grant_out), 64'(0));
    @(negedge sa_clk);
    rst = 1'b0;

    // Two single flits: round-robin serves N then W
    set_flit(PORT_N, mk(4'(PORT_N), FLIT_SINGLE, 30'd1));
    set_flit(PORT_W, mk(4'(PORT_W), FLIT_SINGLE, 30'd2));
    bus.req_in = 5'b00101;
    cycle(5'b00001);
    cycle(5'b00100);
    bus.req_in = '0;
    cycle(5'b00000);
    bus.credit_in = 1'b1;
    repeat (3) cycle(5'b00000);
    bus.credit_in = 1'b0;

    // Wormhole: S holds the output for head/body/tail while E waits
    set_flit(PORT_S, mk(4'(PORT_S), FLIT_HEAD, 30'd10));
    bus.req_in = 5'b00010;
    cycle(5'b00010);
    set_flit(PORT_S, mk(4'(PORT_S), FLIT_BODY, 30'd11));
    set_flit(PORT_E, mk(4'(PORT_E), FLIT_SINGLE, 30'd20));
    bus.req_in = 5'b01010;
    cycle(5'b00010);
    bus.req_in = 5'b01000;
    cycle(5'b00000);
    set_flit(PORT_S, mk(4'(PORT_S), FLIT_TAIL, 30'd12));
    bus.req_in = 5'b01010;
    cycle(5'b00010);
    bus.req_in = 5'b01000;
    cycle(5'b01000);
    bus.req_in = '0;
    bus.credit_in = 1'b1;
    repeat (4) cycle(5'b00000);
    bus.credit_in = 1'b0;

    // Credit exhaustion on Local port
    bus.req_in = 5'b10000;
    for (int i = 0; i < 9; i++) begin
      set_flit(PORT_L, mk(4'(PORT_L), FLIT_SINGLE, 30'(100 + i)));
      cycle((i < 8) ? 5'b10000 : 5'b00000);
    end
    bus.credit_in = 1'b1;
    cycle(5'b00000);
    bus.credit_in = 1'b0;
    set_flit(PORT_L, mk(4'(PORT_L), FLIT_SINGLE, 30'd200));
    cycle(5'b10000);
    cycle(5'b00000);
    cycle(5'b00000);
    bus.req_in = '0;

    // Simultaneous credit return and transfer at credits=3, then saturation
    bus.credit_in = 1'b1;
    repeat (3) cycle(5'b00000);
    set_flit(PORT_L, mk(4'(PORT_L), FLIT_SINGLE, 30'd300));
    bus.req_in = 5'b10000;
    cycle(5'b10000);
    bus.req_in = '0;
    repeat (6) cycle(5'b00000);
    bus.credit_in = 1'b0;

    // Reset while W owns the lock
    set_flit(PORT_W, mk(4'(PORT_W), FLIT_HEAD, 30'd400));
    bus.req_in = 5'b00100;
    cycle(5'b00100);
    set_flit(PORT_W, mk(4'(PORT_W), FLIT_BODY, 30'd401));
    set_flit(PORT_N, mk(4'(PORT_N), FLIT_SINGLE, 30'd402));
    bus.req_in = 5'b00101;
    rst = 1'b1;
    #1;
    chk("locked_grant", 64'(bus.grant_out), 64'(5'b00100));
    @(posedge sa_clk);
    #1;
    chk("rst2_valid", 64'(bus.valid_out), 64'(0));
    chk("rst2_pressure", 64'(bus.pressure_out), 64'(0));
    chk("rst2_data", 64'(bus.data_out), 64'(0));
    model_cr = DP;
    last_flit = '0;
    @(negedge sa_clk);
    rst = 1'b0;
    cycle(5'b00001);
    bus.req_in = '0;
    cycle(5'b00000);

`ifdef SA_LOCK_TIMEOUT_EN
    // Owner S stalls after its head; watchdog frees the output for E
    bus.credit_in = 1'b1;
    cycle(5'b00000);
    bus.credit_in = 1'b0;
    set_flit(PORT_S, mk(4'(PORT_S), FLIT_HEAD, 30'd500));
    bus.req_in = 5'b00010;
    cycle(5'b00010);
    set_flit(PORT_E, mk(4'(PORT_E), FLIT_SINGLE, 30'd501));
    bus.req_in = 5'b01000;
    repeat (6) cycle(5'b00000);
    exp_lock_err = 1'b1;
    cycle(5'b00000);
    cycle(5'b01000);
    bus.req_in = '0;
    cycle(5'b00000);
`endif

    chk("sb_drain", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
